icache_ctrl_nway: RTL

Parametrised N-way set-associative instruction cache controller. Sits between the fetch stage and the external way RAMs plus PLRU RAM, which are synchronous with 1-cycle read latency, and refills lines over an AXI4 read channel. It extends the 2-way controller with:
- a ready/valid fetch handshake
- critical-word-first WRAP bursts with early restart
- a line-buffered single-cycle fill
- fence.i invalidation
- invalid-way-first replacement
- bus-error reporting

---
 rtl/icache_ctrl_nway.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/icache_ctrl_nway.sv
// N-way set-associative instruction cache controller with AXI4 WRAP refill and early restart.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_ctrl_nway #(
    parameter int unsigned ADDR_SIZE      = 32,
    parameter int unsigned WAYS           = 4,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned CACHE_DEPTH    = 64,
    localparam int unsigned WORD_BITS     = $clog2(WORDS_PER_LINE),
    localparam int unsigned INDEX_BITS    = $clog2(CACHE_DEPTH),
    localparam int unsigned TAG_BITS      = ADDR_SIZE - INDEX_BITS - WORD_BITS - 2,
    localparam int unsigned LINE_W        = 1 + TAG_BITS + 32 * WORDS_PER_LINE
) (
    input  logic                     i_clk,
    input  logic                     i_areset_n,
    input  logic                     i_req,
    input  logic [ADDR_SIZE-1:0]     i_addr,
    output logic                     o_ready,
    output logic                     o_instr_valid,
    output logic [31:0]              o_instruction,
    output logic                     o_bus_err,
    input  logic                     i_flush,
    output logic                     o_flush_busy,
    output logic [INDEX_BITS-1:0]    o_addr,
    output logic [WAYS-1:0]          o_we,
    output logic [LINE_W-1:0]        o_line,
    input  logic [WAYS*LINE_W-1:0]   i_line,
    input  logic [WAYS-1:0]          i_rlru,
    output logic [WAYS-1:0]          o_wlru,
    output logic                     o_we_lru,
    output logic                     o_ar_valid,
    input  logic                     i_ar_ready,
    output logic [ADDR_SIZE-1:0]     o_ar_addr,
    output logic [7:0]               o_ar_len,
    output logic [1:0]               o_ar_burst,
    input  logic                     i_r_valid,
    output logic                     o_r_ready,
    input  logic [31:0]              i_r_data,
    input  logic [1:0]               i_r_resp,
    input  logic                     i_r_last
`ifdef ICACHE_PERF_CNT_EN
   ,output logic [31:0]              o_hit_cnt,
    output logic [31:0]              o_miss_cnt
`endif
);

    localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [1:0]  BURST_WRAP = 2'b10;

    typedef enum logic [2:0] {
        ST_FLUSH, ST_IDLE, ST_CHK_TAG, ST_MISS_AR, ST_MISS_R, ST_FILL_WR
    } state_t;

    state_t                               state_q, state_d;
    logic [INDEX_BITS-1:0]                cnt_q;
    logic [ADDR_SIZE-1:0]                 req_addr_q;
    logic [WAY_BITS-1:0]                  victim_q;
    logic [WORDS_PER_LINE-1:0][31:0]      line_buf_q;
    logic [WORD_BITS-1:0]                 wcnt_q;
    logic                                 first_q, err_q, flush_pend_q;

    logic                                 accept, flush_start;
    logic                                 hit_any, inv_found, lru_found;
    logic [WAY_BITS-1:0]                  hit_way, inv_way, lru_way, victim_c, touch_way;
    logic [31:0]                          hit_word;
    logic [WAYS-1:0]                      touch_oh, touch_or, touch_wlru;
    logic                                 unused_addr_lsb;

    wire [INDEX_BITS-1:0] req_idx  = req_addr_q[WORD_BITS+2 +: INDEX_BITS];
    wire [WORD_BITS-1:0]  req_word = req_addr_q[2 +: WORD_BITS];
    wire [TAG_BITS-1:0]   req_tag  = req_addr_q[ADDR_SIZE-1 -: TAG_BITS];

    assign unused_addr_lsb = ^req_addr_q[1:0];
    assign o_flush_busy    = (state_q == ST_FLUSH) || flush_pend_q;

    // Tag compare plus victim choice: first invalid way, else first way with PLRU bit clear.
    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        hit_word  = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_found = 1'b0;
        lru_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit_any && i_line[w*LINE_W + LINE_W - 1]
                && (i_line[w*LINE_W + 32*WORDS_PER_LINE +: TAG_BITS] == req_tag)) begin
                hit_any  = 1'b1;
                hit_way  = WAY_BITS'(w);
                hit_word = i_line[w*LINE_W + 32*32'(req_word) +: 32];
            end
            if (!inv_found && !i_line[w*LINE_W + LINE_W - 1]) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
            if (!lru_found && !i_rlru[w]) begin
                lru_found = 1'b1;
                lru_way   = WAY_BITS'(w);
            end
        end
        victim_c = inv_found ? inv_way : (lru_found ? lru_way : WAY_BITS'(WAYS - 1));
    end

    // PLRU touch: set the way's bit, and restart from just that bit once all are set.
    always_comb begin
        touch_way  = (state_q == ST_CHK_TAG) ? hit_way : victim_q;
        touch_oh   = WAYS'(1) << touch_way;
        touch_or   = i_rlru | touch_oh;
        touch_wlru = (&touch_or) ? touch_oh : touch_or;
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) state_q <= ST_FLUSH;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        flush_start   = 1'b0;
        o_ready       = 1'b0;
        o_instr_valid = 1'b0;
        o_instruction = '0;
        o_bus_err     = 1'b0;
        o_addr        = req_idx;
        o_we          = '0;
        o_line        = '0;
        o_wlru        = '0;
        o_we_lru      = 1'b0;
        o_ar_valid    = 1'b0;
        o_ar_addr     = '0;
        o_ar_len      = '0;
        o_ar_burst    = '0;
        o_r_ready     = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                // Writes are held off while reset is asserted.
                o_addr   = cnt_q;
                o_we     = {WAYS{i_areset_n}};
                o_we_lru = i_areset_n;
                if (cnt_q == INDEX_BITS'(CACHE_DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                o_addr = i_addr[WORD_BITS+2 +: INDEX_BITS];
                if (i_flush || flush_pend_q) begin
                    flush_start = 1'b1;
                    state_d     = ST_FLUSH;
                end else begin
                    o_ready = 1'b1;
                    if (i_req) begin
                        accept  = 1'b1;
                        state_d = ST_CHK_TAG;
                    end
                end
            end
            ST_CHK_TAG: begin
                if (hit_any) begin
                    o_instr_valid = 1'b1;
                    o_instruction = hit_word;
                    o_we_lru      = (WAYS > 1);
                    o_wlru        = touch_wlru;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_MISS_AR;
                end
            end
            ST_MISS_AR: begin
                o_ar_valid = 1'b1;
                o_ar_addr  = {req_addr_q[ADDR_SIZE-1:2], 2'b00};
                o_ar_len   = 8'(WORDS_PER_LINE - 1);
                o_ar_burst = BURST_WRAP;
                if (i_ar_ready) state_d = ST_MISS_R;
            end
            ST_MISS_R: begin
                o_r_ready = 1'b1;
                if (i_r_valid) begin
                    o_instr_valid = first_q;
                    o_instruction = first_q ? i_r_data : 32'd0;
                    o_bus_err     = first_q && (i_r_resp != 2'b00);
                    if (i_r_last) state_d = ST_FILL_WR;
                end
            end
            ST_FILL_WR: begin
                if (!err_q) begin
                    o_we     = WAYS'(1) << victim_q;
                    o_line   = {1'b1, req_tag, line_buf_q};
                    o_we_lru = (WAYS > 1);
                    o_wlru   = touch_wlru;
                end
                if (flush_pend_q || i_flush) begin
                    flush_start = 1'b1;
                    state_d     = ST_FLUSH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    // Request, refill and flush bookkeeping.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            cnt_q        <= '0;
            req_addr_q   <= '0;
            victim_q     <= '0;
            line_buf_q   <= '0;
            wcnt_q       <= '0;
            first_q      <= 1'b0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            if (flush_start)             cnt_q <= '0;
            else if (state_q == ST_FLUSH) cnt_q <= cnt_q + INDEX_BITS'(1);
            if (flush_start)
                flush_pend_q <= 1'b0;
            else if (i_flush && (state_q != ST_IDLE) && (state_q != ST_FLUSH))
                flush_pend_q <= 1'b1;
            if (accept) req_addr_q <= i_addr;
            if (state_q == ST_CHK_TAG) victim_q <= victim_c;
            if (state_q == ST_MISS_AR && i_ar_ready) begin
                wcnt_q  <= req_word;
                first_q <= 1'b1;
                err_q   <= 1'b0;
            end
            if (state_q == ST_MISS_R && i_r_valid) begin
                line_buf_q[wcnt_q] <= i_r_data;
                wcnt_q             <= wcnt_q + WORD_BITS'(1);
                first_q            <= 1'b0;
                err_q              <= err_q || (i_r_resp != 2'b00);
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating lookup counters, untouched by fence.i.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (state_q == ST_CHK_TAG) begin
            if (hit_any && (o_hit_cnt != 32'hFFFF_FFFF))   o_hit_cnt  <= o_hit_cnt + 32'd1;
            if (!hit_any && (o_miss_cnt != 32'hFFFF_FFFF)) o_miss_cnt <= o_miss_cnt + 32'd1;
        end
    end
`endif

endmodule
